// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// the baud-period calculation used to size the oversampling counter.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Clock cycles per serial bit, truncated toward zero.
  function automatic int unsigned calc_cycle(input int unsigned clk_mhz,
                                             input int unsigned baud);
    return (clk_mhz * 32'd1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; both stages reset to 1
// so an idle-high serial line looks idle straight out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a baud-cycle counter, one-entry
// valid/ready output register, single-cycle framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 27,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CYCLE      = calc_cycle(CLK_FREQ, BAUD);
  localparam int unsigned HALF       = CYCLE / 2;
  localparam logic [31:0] CYCLE_LAST = 32'(CYCLE - 1);
  localparam logic [31:0] HALF_LAST  = 32'(HALF - 1);

  logic        rs;
  logic        rs_d;
  state_t      state;
  logic [31:0] cycle_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rs_d      <= 1'b1;
    end else begin
      rs_d      <= rs;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A commit later in this block overrides this consume.
      if (valid && ready) valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          // Only a genuine high-to-low transition arms the receiver.
          if (rs_d && !rs) state <= S_START;
        end

        S_START: begin
          if (cycle_cnt == HALF_LAST) begin
            cycle_cnt <= '0;
            state     <= rs ? S_IDLE : S_DATA;
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end

        S_DATA: begin
          if (cycle_cnt == CYCLE_LAST) begin
            cycle_cnt <= '0;
            shift     <= {rs, shift[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_STOP;
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end

        S_STOP: begin
          if (cycle_cnt == CYCLE_LAST) begin
            cycle_cnt <= '0;
            state     <= S_IDLE;
            if (rs) begin
              if (!valid || ready) begin
                data  <= shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
          end
        end

        default: begin
          state     <= S_IDLE;
          cycle_cnt <= '0;
        end
      endcase
    end
  end

endmodule
